instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Instruction fetch stage and IF/ID pipeline register. Holds the program counter, drives a synchronous-read instruction memory, and registers each returned instruction with its PC+4 for the instruction decode stage (`i_instruction` of the decode top). Accepts a stall from the hazard unit and a redirect (taken branch/jump) from a later stage, and squashes wrong-path fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; bits [1:0] must be 0.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_stall`  in  1  hold the fetch stage and the IF/ID register.
- `i_branch_taken`  in  1  redirect the PC to `i_branch_target`.
- `i_branch_target`  in  32  redirect address; bits [1:0] ignored (treated as 0).
- `o_imem_addr`  out  32  instruction memory address (combinational `= r_pc`).
- `o_imem_en`  out  1  memory read enable; memory holds `i_imem_rdata` when 0.
- `i_imem_rdata`  in  32  instruction word; valid one cycle after an enabled read.
- `o_instruction`  out  32  IF/ID instruction to decode.
- `o_pc_plus4`  out  32  IF/ID PC+4 of `o_instruction`.
- `o_valid`  out  1  IF/ID entry holds a real instruction (0 = bubble).

## Operation
- Internal state: `r_pc` (next address to request), `r_req_pc` (address of read in flight), `r_req_valid` (in-flight read is on the correct path).
- `o_imem_en = !i_stall && !i_branch_taken`.
- Priority per cycle: redirect > stall > normal.
- Normal (`o_imem_en=1`): `r_req_pc<=r_pc`, `r_req_valid<=1`, `r_pc<=r_pc+4`. IF/ID: if `r_req_valid`, `o_instruction<=i_imem_rdata`, `o_pc_plus4<=r_req_pc+4`, `o_valid<=1`; else `o_instruction<=0`, `o_valid<=0`, `o_pc_plus4` holds.
- Stall (no redirect): all registers hold; no new read issued.
- Redirect (regardless of stall): `r_pc<={i_branch_target[31:2],2'b00}`, `r_req_valid<=0`, IF/ID flushed (`o_instruction<=0`, `o_valid<=0`, `o_pc_plus4` holds). Any read in flight is discarded.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFC + 4 = 0`; same for `o_pc_plus4`.

## Timing
- Reset values: `r_pc=RESET_PC`, `r_req_pc=0`, `r_req_valid=0`, `o_instruction=0`, `o_pc_plus4=0`, `o_valid=0`. Reset mid-operation discards all in-flight state immediately.
- First reset release: address `RESET_PC` is issued in cycle 0 and appears on `o_instruction` with `o_valid=1` after the 2nd rising edge.
- Steady state: one instruction per cycle; issue-to-IF/ID latency 2 edges.
- Redirect at edge N: bubble in IF/ID after N and N+1; target instruction valid after edge N+2 (with no stall).
- Stall for k cycles: IF/ID output unchanged for k cycles; the stream resumes without loss or duplication.
- Stall released in the same cycle as a redirect: redirect behaviour.

## Configuration
- `IF_EARLY_JUMP_EN` defined: in a normal cycle, if `r_req_valid` and `i_imem_rdata[31:26]==6'b000010` (J), the jump is still written to IF/ID as valid, and additionally `r_pc<={r_req_pc_plus4[31:28], i_imem_rdata[25:0], 2'b00}` with `r_req_valid<=0` (squash the sequential read issued this cycle). An external redirect in the same cycle takes priority. Penalty: 1 bubble.
- Not defined: J is treated as any other instruction; redirection comes only from `i_branch_taken`.

## Test plan
- Reset with `RESET_PC=32'h0000_0040`, memory returns `mem[a]=a`: `o_imem_addr` = 0x40, 0x44, 0x48…; after edge 2 `o_instruction=0x40`, `o_pc_plus4=0x44`, `o_valid=1`; one per cycle afterwards.
- Stall for 3 cycles while IF/ID holds 0x48: outputs frozen, `o_imem_en=0`; after release, 0x4C follows 0x48 with no gap or repeat.
- Redirect to `32'h0000_0103` at edge N: two bubbles (`o_valid=0`, `o_instruction=0`), then `o_instruction=0x100`, `o_pc_plus4=0x104`.
- Redirect asserted together with stall: redirect wins; target valid 2 edges later.
- `r_pc=32'hFFFF_FFF8`: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; `o_pc_plus4` for 0xFFFFFFFC equals 0.
- With `IF_EARLY_JUMP_EN`, `mem[0x10]=32'h0800_0020` (J 0x80): the J is valid in IF/ID, followed by one bubble, then the instruction at 0x80. Without the macro, 0x14 follows.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, drives a synchronous-read instruction memory and registers each
// returned word with its PC+4 for decode. Handles stall, external redirect and
// squashing of wrong-path reads.
// Optional feature: define IF_EARLY_JUMP_EN to resolve J instructions in fetch.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_en,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  logic [31:0] target_aligned;
  logic [31:0] req_pc_plus4;

  // Low two target bits are forced to zero rather than dropped so the full input is consumed.
  assign target_aligned = i_branch_target & ~32'h0000_0003;
  assign req_pc_plus4   = req_pc_q + 32'd4;

  assign o_imem_addr   = pc_q;
  assign o_imem_en     = !i_stall && !i_branch_taken;
  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_valid       = valid_q;

  // Next-state: redirect beats stall, stall beats normal fetch.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    valid_d     = valid_q;

    if (i_branch_taken) begin
      // Any read in flight is wrong-path; flush IF/ID but keep the last PC+4.
      pc_d        = target_aligned;
      req_valid_d = 1'b0;
      instr_d     = 32'h0;
      valid_d     = 1'b0;
    end else if (!i_stall) begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
      if (req_valid_q) begin
        instr_d    = i_imem_rdata;
        pc_plus4_d = req_pc_plus4;
        valid_d    = 1'b1;
      end else begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
`ifdef IF_EARLY_JUMP_EN
      // J opcode: redirect now and squash the sequential read issued this cycle.
      if (req_valid_q && (i_imem_rdata[31:26] == 6'b000010)) begin
        pc_d        = {req_pc_plus4[31:28], i_imem_rdata[25:0], 2'b00};
        req_valid_d = 1'b0;
      end
`endif
    end
  end

  // State registers; reset discards all in-flight state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      req_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      pc_plus4_q  <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage. Stimulus pushes per-cycle expectations
// derived from a look-back model over the issue history; a negedge monitor pops and checks.
module tb_instruction_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0040;
  localparam int MaxCyc = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(ResetPc)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (target),
    .o_imem_addr     (imem_addr),
    .o_imem_en       (imem_en),
    .i_imem_rdata    (rdata),
    .o_instruction   (instr),
    .o_pc_plus4      (pc4),
    .o_valid         (valid)
  );

  // Memory contents: each word equals its address, except a J at 0x10 (target 0x80).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'h0800_0020 : a;
  endfunction

  // Synchronous-read memory that holds its output when not enabled.
  always @(posedge clk) if (imem_en) rdata <= mem_word(imem_addr);

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        en;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_cyc  = -1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model state.
  logic        iss      [MaxCyc];
  logic [31:0] iss_addr [MaxCyc];
  logic        redir    [MaxCyc];
  logic        killed   [MaxCyc];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          t;

  task automatic model_reset();
    m_pc    = ResetPc;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    t       = 0;
    cur_cyc = -1;
    exp_q.delete();
  endtask

  // Drive one cycle (called just after a rising edge), record expectations, advance.
  task automatic do_cycle(input logic s, input logic b, input logic [31:0] tg);
    exp_t        e;
    logic        found;
    logic        good;
    int          src;
    logic [31:0] next_pc;
    stall   = s;
    br      = b;
    target  = tg;
    cur_cyc = t;
    e.cyc   = t;
    e.addr  = m_pc;
    e.en    = !s && !b;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    exp_q.push_back(e);
    iss[t]      = e.en;
    iss_addr[t] = m_pc;
    redir[t]    = b;
    killed[t]   = 1'b0;
    if (b) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc    = tg & ~32'h0000_0003;
    end else if (!s) begin
      // The word on the memory bus comes from the latest issue; it is good only if
      // nothing but stalls separates it from now and no early jump squashed it.
      found = 1'b0;
      src   = 0;
      for (int k = t - 1; k >= 0; k--) begin
        if (iss[k]) begin
          found = 1'b1;
          src   = k;
          break;
        end
        if (redir[k]) break;
      end
      good = found && !killed[src];
      if (good) begin
        m_valid = 1'b1;
        m_instr = mem_word(iss_addr[src]);
        m_pc4   = iss_addr[src] + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_instr = 32'h0;
      end
      next_pc = m_pc + 32'd4;
`ifdef IF_EARLY_JUMP_EN
      if (good && m_instr[31:26] == 6'b000010) begin
        killed[t] = 1'b1;
        next_pc   = {m_pc4[31:28], m_instr[25:0], 2'b00};
      end
`endif
      m_pc = next_pc;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the queued expectation for the current cycle.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      if (exp_q[0].cyc < cur_cyc) begin
        void'(exp_q.pop_front());
        checks++;
        failures++;
        $display("FAIL stale_entry: expectation for cycle %0d not consumed", cur_cyc);
      end else if (exp_q[0].cyc == cur_cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check32("imem_addr", imem_addr, e.addr);
        check32("imem_en", {31'h0, imem_en}, {31'h0, e.en});
        check32("valid", {31'h0, valid}, {31'h0, e.valid});
        check32("instruction", instr, e.instr);
        check32("pc_plus4", pc4, e.pc4);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check32({tag, "_instr"}, instr, 32'h0);
    check32({tag, "_pc4"}, pc4, 32'h0);
    check32({tag, "_valid"}, {31'h0, valid}, 32'h0);
    check32({tag, "_addr"}, imem_addr, ResetPc);
  endtask

  task automatic rand_cycles(input int n);
    logic        s;
    logic        b;
    logic [31:0] tg;
    for (int i = 0; i < n; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) == 0);
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                       : 32'($urandom_range(0, 2047));
      do_cycle(s, b, tg);
    end
  endtask

  initial begin
    rst    = 1'b1;
    stall  = 1'b0;
    br     = 1'b0;
    target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check32("reset_en", {31'h0, imem_en}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential fetch, then a 3-cycle stall while IF/ID holds 0x48.
    repeat (4) do_cycle(1'b0, 1'b0, 32'h0);
    repeat (3) do_cycle(1'b1, 1'b0, 32'h0);
    repeat (4) do_cycle(1'b0, 1'b0, 32'h0);
    // Unaligned redirect.
    do_cycle(1'b0, 1'b1, 32'h0000_0103);
    repeat (4) do_cycle(1'b0, 1'b0, 32'h0);
    // Redirect together with stall.
    do_cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (4) do_cycle(1'b0, 1'b0, 32'h0);
    // Address wrap-around.
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (5) do_cycle(1'b0, 1'b0, 32'h0);
    // Walk through the J at 0x10.
    do_cycle(1'b0, 1'b1, 32'h0000_0008);
    repeat (8) do_cycle(1'b0, 1'b0, 32'h0);
    // Random traffic.
    rand_cycles(300);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) do_cycle(1'b0, 1'b0, 32'h0);
    rand_cycles(150);
    repeat (3) do_cycle(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required at most 1", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
